// File: rtl/axi4_lite_master_pkg.sv
// ----------------------------------------------------------------------------
// axi4_lite_master_pkg
// Shared configuration for the AXI4-Lite master slice:
//   - default bus widths (address, data, strobe, response)
//   - default watchdog limit
//   - FSM state encodings (plain 3-bit constants for legacy tooling)
//   - AXI response codes
// ----------------------------------------------------------------------------
package axi4_lite_master_pkg;

    localparam int AXI_ADDR_W         = 32;
    localparam int AXI_DATA_W         = 32;
    localparam int AXI_MASK_W         = AXI_DATA_W / 8;
    localparam int AXI_RESP_W         = 2;
    localparam int TIMEOUT_CYCLES_DEF = 1024;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_ADDR = 3'd1;
    localparam logic [2:0] ST_RD_DATA = 3'd2;
    localparam logic [2:0] ST_WR_REQ  = 3'd3;
    localparam logic [2:0] ST_WR_RESP = 3'd4;
    localparam logic [2:0] ST_RSP     = 3'd5;

    localparam logic [AXI_RESP_W-1:0] RESP_OKAY   = 2'd0;
    localparam logic [AXI_RESP_W-1:0] RESP_SLVERR = 2'd2;
    localparam logic [AXI_RESP_W-1:0] RESP_DECERR = 2'd3;

endpackage

// File: rtl/axi4_lite_master_if.sv
// ----------------------------------------------------------------------------
// axi4_lite_master_if
// AXI4-Lite channel bundle (AR, R, AW, W, B).
//   modport master : drives AR/AW/W payload+valid, R/B ready
//   modport slave  : drives AR/AW/W ready, R/B payload+valid
// ----------------------------------------------------------------------------
interface axi4_lite_master_if
    import axi4_lite_master_pkg::*;
#(
    parameter int ADDR_WIDTH = AXI_ADDR_W,
    parameter int DATA_WIDTH = AXI_DATA_W,
    parameter int MASK_WIDTH = AXI_MASK_W,
    parameter int RESP_WIDTH = AXI_RESP_W
);
    logic                  ar_valid;
    logic [ADDR_WIDTH-1:0] ar_bits_addr;
    logic                  ar_ready;

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_bits_data;
    logic [RESP_WIDTH-1:0] r_bits_resp;
    logic                  r_ready;

    logic                  aw_valid;
    logic [ADDR_WIDTH-1:0] aw_bits_addr;
    logic                  aw_ready;

    logic                  w_valid;
    logic [DATA_WIDTH-1:0] w_bits_data;
    logic [MASK_WIDTH-1:0] w_bits_strb;
    logic                  w_ready;

    logic                  b_valid;
    logic [RESP_WIDTH-1:0] b_bits_resp;
    logic                  b_ready;

    modport master (
        output ar_valid, ar_bits_addr, input  ar_ready,
        input  r_valid, r_bits_data, r_bits_resp, output r_ready,
        output aw_valid, aw_bits_addr, input  aw_ready,
        output w_valid, w_bits_data, w_bits_strb, input  w_ready,
        input  b_valid, b_bits_resp, output b_ready
    );

    modport slave (
        input  ar_valid, ar_bits_addr, output ar_ready,
        output r_valid, r_bits_data, r_bits_resp, input  r_ready,
        input  aw_valid, aw_bits_addr, output aw_ready,
        input  w_valid, w_bits_data, w_bits_strb, output w_ready,
        output b_valid, b_bits_resp, input  b_ready
    );

endinterface

// File: rtl/axi4_lite_master_wdog.sv
// ----------------------------------------------------------------------------
// axi4_lite_master_wdog
// Transaction watchdog. Counts cycles since the last clear; when the count
// reaches TIMEOUT_CYCLES the sticky timeout flag is raised until iReset.
// The counter saturates at the limit.
// Ports:
//   iClock, iReset : clock, synchronous active-high reset
//   clear_i        : restart the count (idle or any AXI handshake)
//   timeout_o      : sticky timeout flag
// ----------------------------------------------------------------------------
module axi4_lite_master_wdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic iClock,
    input  logic iReset,
    input  logic clear_i,
    output logic timeout_o
);
    localparam int               CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (cnt_d == LIMIT) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;

endmodule

// File: rtl/axi4_lite_master.sv
// ----------------------------------------------------------------------------
// axi4_lite_master
// Single-outstanding AXI4-Lite master: turns a core load/store request into
// one AXI4-Lite read or write and returns data + response code to the core.
// Optional watchdog: define AXI4_LITE_MASTER_TIMEOUT_EN to enable oTimeout.
// Ports:
//   iClock, iReset           : clock, synchronous active-high reset
//   iReqValid/oReqReady      : request handshake (ready only in IDLE)
//   iReqWrite/Addr/Data/Mask : request payload
//   oRspValid/iRspReady      : response handshake
//   oRspData/oRspResp        : read data (0 for writes), RRESP/BRESP
//   oTimeout                 : sticky watchdog flag (0 when disabled)
//   pAXI4                    : AXI4-Lite master channels
// ----------------------------------------------------------------------------
module axi4_lite_master
    import axi4_lite_master_pkg::*;
#(
    parameter int ADDR_WIDTH     = AXI_ADDR_W,
    parameter int DATA_WIDTH     = AXI_DATA_W,
    parameter int MASK_WIDTH     = AXI_MASK_W,
    parameter int RESP_WIDTH     = AXI_RESP_W,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                  iClock,
    input  logic                  iReset,
    input  logic                  iReqValid,
    input  logic                  iReqWrite,
    input  logic [ADDR_WIDTH-1:0] iReqAddr,
    input  logic [DATA_WIDTH-1:0] iReqData,
    input  logic [MASK_WIDTH-1:0] iReqMask,
    output logic                  oReqReady,
    output logic                  oRspValid,
    output logic [DATA_WIDTH-1:0] oRspData,
    output logic [RESP_WIDTH-1:0] oRspResp,
    input  logic                  iRspReady,
    output logic                  oTimeout,
    axi4_lite_master_if.master    pAXI4
);
    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [MASK_WIDTH-1:0] mask_q, mask_d;
    logic                  ar_valid_q, ar_valid_d;
    logic                  r_ready_q, r_ready_d;
    logic                  aw_valid_q, aw_valid_d;
    logic                  w_valid_q, w_valid_d;
    logic                  b_ready_q, b_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [RESP_WIDTH-1:0] rsp_resp_q, rsp_resp_d;

    logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic aw_done, w_done;

    assign ar_hs = ar_valid_q && pAXI4.ar_ready;
    assign r_hs  = r_ready_q  && pAXI4.r_valid;
    assign aw_hs = aw_valid_q && pAXI4.aw_ready;
    assign w_hs  = w_valid_q  && pAXI4.w_ready;
    assign b_hs  = b_ready_q  && pAXI4.b_valid;

    // A write channel is done once its valid has dropped or it handshakes now;
    // this lets AW and W complete in either order or in the same cycle.
    assign aw_done = !aw_valid_q || aw_hs;
    assign w_done  = !w_valid_q  || w_hs;

    // NOTE: every _d takes its _q value first, so no branch leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        data_d      = data_q;
        mask_d      = mask_q;
        ar_valid_d  = ar_valid_q;
        r_ready_d   = r_ready_q;
        aw_valid_d  = aw_valid_q;
        w_valid_d   = w_valid_q;
        b_ready_d   = b_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_resp_d  = rsp_resp_q;

        case (state_q)
            ST_IDLE: begin
                if (iReqValid) begin
                    addr_d = iReqAddr;
                    data_d = iReqData;
                    mask_d = iReqMask;
                    if (iReqWrite) begin
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                        state_d    = ST_WR_REQ;
                    end else begin
                        ar_valid_d = 1'b1;
                        state_d    = ST_RD_ADDR;
                    end
                end
            end
            ST_RD_ADDR: begin
                if (ar_hs) begin
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                    state_d    = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (r_hs) begin
                    rsp_data_d  = pAXI4.r_bits_data;
                    rsp_resp_d  = pAXI4.r_bits_resp;
                    r_ready_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RSP;
                end
            end
            ST_WR_REQ: begin
                if (aw_hs) aw_valid_d = 1'b0;
                if (w_hs)  w_valid_d  = 1'b0;
                if (aw_done && w_done) begin
                    b_ready_d = 1'b1;
                    state_d   = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (b_hs) begin
                    rsp_data_d  = '0;
                    rsp_resp_d  = pAXI4.b_bits_resp;
                    b_ready_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RSP;
                end
            end
            ST_RSP: begin
                if (iRspReady) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: synchronous reset clears payload registers too, so the bus never carries X after reset.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            mask_q      <= '0;
            ar_valid_q  <= 1'b0;
            r_ready_q   <= 1'b0;
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            b_ready_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_resp_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            mask_q      <= mask_d;
            ar_valid_q  <= ar_valid_d;
            r_ready_q   <= r_ready_d;
            aw_valid_q  <= aw_valid_d;
            w_valid_q   <= w_valid_d;
            b_ready_q   <= b_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    assign oReqReady = (state_q == ST_IDLE);
    assign oRspValid = rsp_valid_q;
    assign oRspData  = rsp_data_q;
    assign oRspResp  = rsp_resp_q;

    // Address register is shared by AR and AW; only one of them is ever valid.
    assign pAXI4.ar_valid     = ar_valid_q;
    assign pAXI4.ar_bits_addr = addr_q;
    assign pAXI4.r_ready      = r_ready_q;
    assign pAXI4.aw_valid     = aw_valid_q;
    assign pAXI4.aw_bits_addr = addr_q;
    assign pAXI4.w_valid      = w_valid_q;
    assign pAXI4.w_bits_data  = data_q;
    assign pAXI4.w_bits_strb  = mask_q;
    assign pAXI4.b_ready      = b_ready_q;

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
    logic wdog_clear;
    assign wdog_clear = (state_q == ST_IDLE) || ar_hs || r_hs || aw_hs || w_hs || b_hs;

    axi4_lite_master_wdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .iClock    (iClock),
        .iReset    (iReset),
        .clear_i   (wdog_clear),
        .timeout_o (oTimeout)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign oTimeout           = 1'b0;
`endif

endmodule
